// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the rename-history-table (RHT) rollback logic.
//   RHT_DEPTH / L_ADDR_WIDTH / P_ADDR_WIDTH : default table and register sizes
//   rht_id_t    : RHT entry id at the default depth
//   rb_state_t  : rollback FSM states
//   rht_dec     : circular decrement of an RHT id
//   rht_age     : distance of an id behind a captured tail (circular)
// ---------------------------------------------------------------------------
package rr_pkg;

    localparam int RHT_DEPTH    = 128;
    localparam int L_ADDR_WIDTH = 5;
    localparam int P_ADDR_WIDTH = 8;

    typedef logic [$clog2(RHT_DEPTH)-1:0] rht_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } rb_state_t;

    // Depth is passed in so a module overriding RHT_DEPTH gets its own wrap
    // point; the depth need not be a power of two.
    function automatic int unsigned rht_dec(input int unsigned x,
                                            input int unsigned depth);
        return (x == 0) ? depth - 1 : x - 1;
    endfunction

    // Age 0 is the tail itself; larger values are older entries.
    function automatic int unsigned rht_age(input int unsigned tail,
                                            input int unsigned x,
                                            input int unsigned depth);
        return (tail >= x) ? tail - x : tail + depth - x;
    endfunction

endpackage

// File: rtl/rht_rollback.sv
// ---------------------------------------------------------------------------
// rht_rollback
// Undoes speculative renames after a misprediction by walking the RHT from
// the youngest entry down to the flushed one, restoring each entry's prior
// physical mapping into the RAT, then redirecting the RHT tail.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush_valid/_id    : flush request and oldest RHT entry to undo
//   tail_in            : current RHT tail (next free id)
//   rd_id              : RHT read address
//   rd_Ldst, rd_Pdst   : RHT read data (combinational from rd_id)
//   rat_wr_en/_Laddr/_Pdata : RAT restore write port
//   set_ptr, new_pointer    : one-cycle RHT tail redirect
//   busy               : rollback in progress, rename stalls
// ---------------------------------------------------------------------------
module rht_rollback
    import rr_pkg::*;
#(
    parameter int RHT_DEPTH    = rr_pkg::RHT_DEPTH,
    parameter int L_ADDR_WIDTH = rr_pkg::L_ADDR_WIDTH,
    parameter int P_ADDR_WIDTH = rr_pkg::P_ADDR_WIDTH,
    parameter int IDW          = $clog2(RHT_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_valid,
    input  logic [IDW-1:0]          flush_id,
    input  logic [IDW-1:0]          tail_in,
    output logic [IDW-1:0]          rd_id,
    input  logic [L_ADDR_WIDTH-1:0] rd_Ldst,
    input  logic [P_ADDR_WIDTH-1:0] rd_Pdst,
    output logic                    rat_wr_en,
    output logic [L_ADDR_WIDTH-1:0] rat_wr_Laddr,
    output logic [P_ADDR_WIDTH-1:0] rat_wr_Pdata,
    output logic                    set_ptr,
    output logic [IDW-1:0]          new_pointer,
    output logic                    busy
);

    localparam int unsigned DEPTH_U = unsigned'(RHT_DEPTH);

    rb_state_t      state_q, state_d;
    logic [IDW-1:0] cur_id_q, cur_id_d;
    logic [IDW-1:0] stop_id_q, stop_id_d;
    logic [IDW-1:0] tail_snap_q, tail_snap_d;

    logic [IDW-1:0] tail_dec;
    logic [IDW-1:0] cur_dec;
    logic [IDW:0]   age_flush;
    logic [IDW:0]   age_stop;
    logic           extend;

    assign tail_dec  = IDW'(rht_dec(32'(tail_in), DEPTH_U));
    assign cur_dec   = IDW'(rht_dec(32'(cur_id_q), DEPTH_U));
    assign age_flush = (IDW+1)'(rht_age(32'(tail_snap_q), 32'(flush_id), DEPTH_U));
    assign age_stop  = (IDW+1)'(rht_age(32'(tail_snap_q), 32'(stop_id_q), DEPTH_U));
    // A flush during the walk only matters if it reaches further back.
    assign extend    = flush_valid && (age_flush > age_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            stop_id_q   <= '0;
            tail_snap_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            stop_id_q   <= stop_id_d;
            tail_snap_q <= tail_snap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        stop_id_d   = stop_id_q;
        tail_snap_d = tail_snap_q;
        case (state_q)
            IDLE: begin
                if (flush_valid) begin
                    stop_id_d   = flush_id;
                    cur_id_d    = tail_dec;
                    tail_snap_d = tail_in;
                    state_d     = (flush_id != tail_in) ? WALK : DONE;
                end
            end
            WALK: begin
                if (extend) begin
                    stop_id_d = flush_id;
                end
                // Restored entries are never revisited: an extension only
                // moves the stop point, so the walk just keeps decrementing.
                if (cur_id_q == stop_id_q && !extend) begin
                    state_d = DONE;
                end else begin
                    cur_id_d = cur_dec;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state and the RHT read data, so a
    // late flush or tail change cannot glitch the RAT write port.
    always_comb begin
        rd_id        = '0;
        rat_wr_en    = 1'b0;
        rat_wr_Laddr = '0;
        rat_wr_Pdata = '0;
        set_ptr      = 1'b0;
        new_pointer  = '0;
        busy         = 1'b0;
        case (state_q)
            WALK: begin
                busy         = 1'b1;
                rd_id        = cur_id_q;
                rat_wr_en    = 1'b1;
                rat_wr_Laddr = rd_Ldst;
                rat_wr_Pdata = rd_Pdst;
            end
            DONE: begin
                busy        = 1'b1;
                set_ptr     = 1'b1;
                new_pointer = stop_id_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/rht_rollback.md
RHT_ROLLBACK -- requirements
Module: rht_rollback

Interface
REQ-001 Parameter RHT_DEPTH, default 128, number of RHT entries; need not be a power of two.
REQ-002 Parameter L_ADDR_WIDTH, default 5, logical register index width.
REQ-003 Parameter P_ADDR_WIDTH, default 8, physical register index width.
REQ-004 Parameter IDW, default $clog2(RHT_DEPTH), RHT id width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 flush_valid  in  1  misprediction flush request.
REQ-008 flush_id  in  IDW  oldest RHT entry to undo.
REQ-009 tail_in  in  IDW  current RHT tail, i.e. next free id.
REQ-010 rd_id  out  IDW  RHT read address.
REQ-011 rd_Ldst  in  L_ADDR_WIDTH  RHT read data, logical register; combinational from rd_id.
REQ-012 rd_Pdst  in  P_ADDR_WIDTH  RHT read data, prior physical mapping; combinational from rd_id.
REQ-013 rat_wr_en  out  1  RAT restore write strobe.
REQ-014 rat_wr_Laddr  out  L_ADDR_WIDTH  RAT index to restore.
REQ-015 rat_wr_Pdata  out  P_ADDR_WIDTH  mapping to restore.
REQ-016 set_ptr  out  1  one-cycle RHT tail redirect strobe.
REQ-017 new_pointer  out  IDW  redirected tail value.
REQ-018 busy  out  1  rollback in progress; rename stalls while high.

Function
REQ-019 FSM states: IDLE, WALK, DONE.
REQ-020 In IDLE with flush_valid: capture stop_id=flush_id and cur_id=dec(tail_in); go to WALK if flush_id!=tail_in, else go directly to DONE.
REQ-021 dec(x) SHALL be x-1, except that dec(0)=RHT_DEPTH-1.
REQ-022 In WALK: rd_id=cur_id; rat_wr_en=1; rat_wr_Laddr=rd_Ldst; rat_wr_Pdata=rd_Pdst; all in the same cycle.
REQ-023 WALK order: youngest to oldest (tail_in-1 down to stop_id), so the last write per register leaves the oldest prior mapping.
REQ-024 In WALK: if cur_id==stop_id, next state is DONE; else cur_id<=dec(cur_id).
REQ-025 In DONE: set_ptr=1 and new_pointer=stop_id for exactly one cycle, rat_wr_en=0; next state IDLE.
REQ-026 busy SHALL be 1 in WALK and DONE, and 0 in IDLE.
REQ-027 Timing: for N=(tail_in-flush_id) mod RHT_DEPTH entries, busy is high for N+1 cycles starting the cycle after flush_valid; N=0 gives a single DONE cycle.
REQ-028 age(x) SHALL be (tail_snap-x) mod RHT_DEPTH, using the tail_in captured at flush acceptance; width IDW+1, no overflow.
REQ-029 flush_valid in WALK: if age(flush_id)>age(stop_id), update stop_id=flush_id (deeper rollback); otherwise ignore.
REQ-030 flush_valid in DONE SHALL be ignored.
REQ-031 Entries already restored are never rewritten after a stop_id extension; the walk simply continues further.
REQ-032 In IDLE: rat_wr_en=0, set_ptr=0, rd_id=0.
REQ-033 Outputs other than rd_id SHALL be driven from registered state plus the combinational rd_* inputs only; flush_* and tail_in SHALL NOT feed them combinationally.

Reset
REQ-034 On rst_n low: state=IDLE, cur_id=0, stop_id=0, tail_snap=0, immediately, regardless of clk.
REQ-035 During reset all outputs are 0, including busy, set_ptr and rat_wr_en.
REQ-036 Reset during WALK abandons the walk; no set_ptr is issued afterwards.

Structure
REQ-037 Shared package rr_pkg SHALL hold RHT_DEPTH, L_ADDR_WIDTH, P_ADDR_WIDTH, typedef rht_id_t, the FSM state enum rb_state_t, and functions rht_dec and rht_age.
REQ-038 No sub-module; single flat module, est. 150-250 lines RTL.

Verification
REQ-039 tail_in=10, flush_id=7 -> WALK reads ids 9,8,7 on consecutive cycles with rat_wr_en=1; next cycle set_ptr=1, new_pointer=7; busy high 4 cycles.
REQ-040 Wrap: RHT_DEPTH=128, tail_in=2, flush_id=126 -> reads 1,0,127,126; then set_ptr with new_pointer=126.
REQ-041 flush_id==tail_in=40 -> no RAT writes; set_ptr=1, new_pointer=40 the next cycle; busy high 1 cycle.
REQ-042 tail_in=20, flush_id=15; second flush with flush_id=12 during the 2nd WALK cycle -> walk continues to 12 (8 writes), new_pointer=12; a second flush with flush_id=18 instead is ignored.
REQ-043 rst_n asserted mid-WALK after 2 writes -> busy, rat_wr_en, set_ptr drop to 0 immediately; no set_ptr after release.
REQ-044 Same Ldst in ids 9 (Pdst 33) and 7 (Pdst 21) -> final RAT value for that Ldst is 21.
